// File: rtl/emmc_cmd_tx.sv
// eMMC CMD line transmit sequencer: serialises start/dir/index/arg/CRC7/end, MSB first.
// Optional response wait (NCR timeout) enabled by defining EMMC_CMD_RSP_WAIT_EN.
module emmc_cmd_tx #(
  parameter int NCC_GAP = 8,
  parameter int NCR_MAX = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bit_tick,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic        cmd_in,
  output logic        cmd_out,
  output logic        cmd_oe,
  output logic        busy,
  output logic        done,
  output logic        rsp_timeout
);

  localparam int CNT_MAX = (NCR_MAX > NCC_GAP) ? NCR_MAX : NCC_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    CRC,
    END,
`ifdef EMMC_CMD_RSP_WAIT_EN
    GAP,
    RSP_WAIT
`else
    GAP
`endif
  } state_t;

  state_t          state;
  logic [39:0]     shreg;
  logic [6:0]      crc;
  logic [5:0]      bitcnt;
  logic [CW-1:0]   cnt;

`ifdef EMMC_CMD_RSP_WAIT_EN
  logic            is_cmd0;
`else
  logic            unused_cmd_in;
  assign unused_cmd_in = cmd_in;
`endif

  // CRC7 step for G(x) = x^7 + x^3 + 1 folding in one data bit
  function automatic logic [6:0] crc_next(input logic [6:0] c, input logic d);
    crc_next = {c[5], c[4], c[3], d ^ c[2] ^ c[6], c[1], c[0], d ^ c[6]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cmd_ready   <= 1'b0;
      cmd_out     <= 1'b1;
      cmd_oe      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rsp_timeout <= 1'b0;
      crc         <= 7'd0;
      shreg       <= 40'd0;
      bitcnt      <= 6'd0;
      cnt         <= '0;
`ifdef EMMC_CMD_RSP_WAIT_EN
      is_cmd0     <= 1'b0;
`endif
    end else begin
      done        <= 1'b0;
      rsp_timeout <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          cmd_oe    <= 1'b0;
          cmd_out   <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            shreg     <= {2'b01, cmd_index, cmd_arg};
            crc       <= 7'd0;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
            state     <= LOAD;
`ifdef EMMC_CMD_RSP_WAIT_EN
            is_cmd0   <= (cmd_index == 6'd0);
`endif
          end
        end
        // Start bit goes out here so the accept-cycle tick is never used
        LOAD: if (bit_tick) begin
          cmd_oe  <= 1'b1;
          cmd_out <= shreg[39];
          crc     <= crc_next(crc, shreg[39]);
          shreg   <= {shreg[38:0], 1'b0};
          bitcnt  <= 6'd39;
          state   <= SHIFT;
        end
        SHIFT: if (bit_tick) begin
          cmd_out <= shreg[39];
          crc     <= crc_next(crc, shreg[39]);
          shreg   <= {shreg[38:0], 1'b0};
          if (bitcnt == 6'd1) begin
            bitcnt <= 6'd7;
            state  <= CRC;
          end else begin
            bitcnt <= bitcnt - 6'd1;
          end
        end
        CRC: if (bit_tick) begin
          cmd_out <= crc[6];
          crc     <= {crc[5:0], 1'b0};
          if (bitcnt == 6'd1) state <= END;
          else                bitcnt <= bitcnt - 6'd1;
        end
        END: if (bit_tick) begin
          cmd_out <= 1'b1;
          cnt     <= '0;
`ifdef EMMC_CMD_RSP_WAIT_EN
          state   <= is_cmd0 ? GAP : RSP_WAIT;
`else
          state   <= GAP;
`endif
        end
        // First tick here ends the end-bit period; NCC_GAP idle periods follow
        GAP: if (bit_tick) begin
          cmd_oe  <= 1'b0;
          cmd_out <= 1'b1;
          if (cnt == CW'(NCC_GAP)) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            cmd_ready <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`ifdef EMMC_CMD_RSP_WAIT_EN
        RSP_WAIT: if (bit_tick) begin
          cmd_oe  <= 1'b0;
          cmd_out <= 1'b1;
          if (!cmd_in) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            cmd_ready <= 1'b1;
          end else if (cnt == CW'(NCR_MAX - 1)) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b1;
            rsp_timeout <= 1'b1;
            cmd_ready   <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_emmc_cmd_tx.sv
// Self-checking bench for emmc_cmd_tx: spec vectors, back-to-back, mid-frame reset, random commands.
// Compares the captured CMD stream against a CRC7 frame model and tick-count timing rules.
module tb_emmc_cmd_tx;

  localparam int NCC_GAP     = 8;
  localparam int NCR_MAX     = 64;
  localparam int FRAME_BITS  = 48;
  localparam int CYCLE_BOUND = 4000;
`ifdef EMMC_CMD_RSP_WAIT_EN
  localparam bit RSP_WAIT_EN = 1'b1;
`else
  localparam bit RSP_WAIT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        bit_tick;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        cmd_in;
  logic        cmd_out;
  logic        cmd_oe;
  logic        busy;
  logic        done;
  logic        rsp_timeout;

  int testsRun    = 0;
  int testsFailed = 0;
  int tickDiv     = 1;
  int divCnt      = 0;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    int          div;
    logic [47:0] frame;
  } vec_t;

  vec_t        vecs[4];
  logic [5:0]  rIdx;
  logic [31:0] rArg;

  emmc_cmd_tx #(.NCC_GAP(NCC_GAP), .NCR_MAX(NCR_MAX)) dut (
    .clk(clk), .rst(rst), .bit_tick(bit_tick),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_index(cmd_index), .cmd_arg(cmd_arg), .cmd_in(cmd_in),
    .cmd_out(cmd_out), .cmd_oe(cmd_oe), .busy(busy),
    .done(done), .rsp_timeout(rsp_timeout)
  );

  always #5 clk = ~clk;

  // Bit-tick source: every tickDiv clocks, or random density when tickDiv is 0
  initial begin
    bit_tick = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (tickDiv == 0) begin
        bit_tick = ($urandom_range(0, 2) == 0);
      end else if (divCnt >= tickDiv - 1) begin
        bit_tick = 1'b1;
        divCnt = 0;
      end else begin
        bit_tick = 1'b0;
        divCnt++;
      end
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Frame = {01, index, arg, CRC7 over those 40 bits, end bit 1}
  function automatic logic [47:0] modelFrame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] body;
    int crc;
    int fb;
    body = {2'b01, idx, arg};
    crc = 0;
    for (int i = 39; i >= 0; i--) begin
      fb = (body[i] ? 1 : 0) ^ ((crc >> 6) & 1);
      crc = (crc << 1) & 'h7f;
      if (fb != 0) crc = crc ^ 'h09;
    end
    modelFrame = {body, 7'(crc), 1'b1};
  endfunction

  // Tick number (counted from accept) on which done is expected
  function automatic int modelDoneTick(input logic [5:0] idx, input int rspAfter);
    if (RSP_WAIT_EN && idx != 6'd0)
      modelDoneTick = (rspAfter > 0) ? FRAME_BITS + rspAfter : FRAME_BITS + NCR_MAX;
    else
      modelDoneTick = FRAME_BITS + 1 + NCC_GAP;
  endfunction

  function automatic bit modelTimeout(input logic [5:0] idx, input int rspAfter);
    modelTimeout = RSP_WAIT_EN && (idx != 6'd0) && (rspAfter == 0);
  endfunction

  task automatic applyStimulus(input logic [5:0] idx, input logic [31:0] arg, input logic [47:0] expFrame,
                               input bit keepValid, input int expWait, input int abortTick,
                               input int rspAfter, input string name);
    int cyc, ticks, doneTick, oeCount, holdErr, gapErr, protoErr, strayTimeout;
    logic [47:0] got;
    logic lastOut, lastOe, readyBefore, tickNow, timeoutAtDone;
    bit accepted, finished;
    cyc = 0; ticks = 0; doneTick = -1; oeCount = 0; holdErr = 0; gapErr = 0;
    protoErr = 0; strayTimeout = 0; got = '0; timeoutAtDone = 1'b0;
    accepted = 1'b0; finished = 1'b0; readyBefore = 1'b0;
    while (!accepted && cyc < CYCLE_BOUND) begin
      @(negedge clk);
      readyBefore = cmd_ready;
      cmd_valid = 1'b1;
      cmd_index = idx;
      cmd_arg   = arg;
      @(posedge clk);
      cyc++;
      accepted = readyBefore;
    end
    checkOutput({name, "/accepted"}, 64'(accepted), 64'(1));
    if (!accepted) return;
    if (expWait > 0) checkOutput({name, "/accept_wait"}, 64'(cyc), 64'(expWait));
    #1;
    checkOutput({name, "/post_accept"}, 64'({busy, cmd_ready, done, cmd_oe, cmd_out}), 64'(5'b10001));
    cyc = 0;
    while (!finished && cyc < CYCLE_BOUND) begin
      @(negedge clk);
      cmd_valid = keepValid;
      cmd_index = 6'($urandom);
      cmd_arg   = $urandom;
      if (RSP_WAIT_EN)
        cmd_in = (rspAfter > 0 && ticks >= FRAME_BITS + rspAfter - 1) ? 1'b0 : 1'b1;
      else
        cmd_in = 1'($urandom);
      tickNow = bit_tick;
      lastOut = cmd_out;
      lastOe  = cmd_oe;
      @(posedge clk);
      #1;
      cyc++;
      if (tickNow) ticks++;
      if (!tickNow && (cmd_out !== lastOut || cmd_oe !== lastOe)) holdErr++;
      if (tickNow && ticks <= FRAME_BITS) begin
        got = {got[46:0], cmd_out};
        if (cmd_oe === 1'b1) oeCount++;
      end
      if (ticks > FRAME_BITS && !done && (cmd_oe !== 1'b0 || cmd_out !== 1'b1)) gapErr++;
      if ((busy && cmd_ready) || (!done && !busy)) protoErr++;
      if (rsp_timeout && !done) strayTimeout++;
      if (done) begin
        doneTick = ticks;
        timeoutAtDone = rsp_timeout;
        finished = 1'b1;
        checkOutput({name, "/done_state"}, 64'({busy, cmd_ready, cmd_oe, cmd_out}), 64'(4'b0101));
      end
      if (abortTick > 0 && tickNow && ticks == abortTick) begin
        checkOutput({name, "/bits_before_abort"}, 64'(got), 64'(expFrame >> (FRAME_BITS - abortTick)));
        @(negedge clk);
        rst = 1'b1;
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput({name, "/reset_cycle"}, 64'({cmd_oe, cmd_out, busy, cmd_ready, done, rsp_timeout}),
                    64'(6'b010000));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput({name, "/after_reset"}, 64'({cmd_ready, cmd_oe, cmd_out, busy}), 64'(4'b1010));
        return;
      end
    end
    checkOutput({name, "/done_seen"}, 64'(finished), 64'(1));
    checkOutput({name, "/frame"}, 64'(got), 64'(expFrame));
    checkOutput({name, "/oe_bits"}, 64'(oeCount), 64'(FRAME_BITS));
    checkOutput({name, "/bit_hold"}, 64'(holdErr), 64'(0));
    checkOutput({name, "/idle_after_end"}, 64'(gapErr), 64'(0));
    checkOutput({name, "/busy_ready"}, 64'(protoErr), 64'(0));
    checkOutput({name, "/stray_timeout"}, 64'(strayTimeout), 64'(0));
    checkOutput({name, "/done_tick"}, 64'(doneTick), 64'(modelDoneTick(idx, rspAfter)));
    checkOutput({name, "/rsp_timeout"}, 64'(timeoutAtDone), 64'(modelTimeout(idx, rspAfter)));
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_index = 6'd0;
    cmd_arg = 32'd0;
    cmd_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_outputs", 64'({cmd_ready, cmd_out, cmd_oe, busy, done, rsp_timeout}), 64'(6'b010000));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("ready_after_reset", 64'(cmd_ready), 64'(1));

    vecs[0] = '{6'd0,  32'h0000_0000, 1, 48'h4000_0000_0095};
    vecs[1] = '{6'd8,  32'h0000_01AA, 2, 48'h4800_0001_AA87};
    vecs[2] = '{6'd17, 32'h0000_0000, 4, 48'h5100_0000_0055};
    vecs[3] = '{6'd63, 32'hFFFF_FFFF, 3, modelFrame(6'd63, 32'hFFFF_FFFF)};
    for (int i = 0; i < 4; i++) begin
      tickDiv = vecs[i].div;
      applyStimulus(vecs[i].idx, vecs[i].arg, vecs[i].frame, 1'b0, 0, 0, 0, $sformatf("vec%0d", i));
    end

    tickDiv = 2;
    applyStimulus(6'd8, 32'h1AA, 48'h4800_0001_AA87, 1'b1, 0, 0, 0, "b2b_first");
    tickDiv = 1;
    applyStimulus(6'd17, 32'h0, 48'h5100_0000_0055, 1'b0, 1, 0, 0, "b2b_second");

    tickDiv = 2;
    applyStimulus(6'd8, 32'h1AA, 48'h4800_0001_AA87, 1'b0, 0, 20, 0, "abort_cmd8");
    applyStimulus(6'd0, 32'h0, 48'h4000_0000_0095, 1'b0, 0, 0, 0, "cmd0_after_abort");

`ifdef EMMC_CMD_RSP_WAIT_EN
    tickDiv = 1;
    applyStimulus(6'd8, 32'h1AA, 48'h4800_0001_AA87, 1'b0, 0, 0, 0, "rsp_none");
    applyStimulus(6'd8, 32'h1AA, 48'h4800_0001_AA87, 1'b0, 0, 0, 5, "rsp_at_5");
`endif

    for (int i = 0; i < 8; i++) begin
      rIdx = 6'($urandom);
      rArg = $urandom;
      tickDiv = $urandom_range(0, 3);
      applyStimulus(rIdx, rArg, modelFrame(rIdx, rArg), 1'b0, 0, 0, $urandom_range(0, 20),
                    $sformatf("rand%0d", i));
    end

    @(posedge clk);
    #1;
    checkOutput("done_single_pulse", 64'(done), 64'(0));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
